// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: FSM encoding, prefix bytes,
// the decoded key record and the odd-parity helper.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
    localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;
    localparam int         PS2_FRAME_BITS   = 8;

    typedef struct packed {
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } ps2_key_t;

    // Odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic ps2_odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 pin conditioning: 2-flop synchronizers on both lines, a FILTER_LEN-sample
// level filter on the clock line and a one-cycle strobe on its falling edge.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_dat,
    output logic dat_sync,
    output logic clk_fall
);
    localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic [1:0]    clk_sr;
    logic [1:0]    dat_sr;
    logic          clk_filt;
    logic [CW-1:0] flt_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            clk_sr   <= 2'b11;
            dat_sr   <= 2'b11;
            clk_filt <= 1'b1;
            flt_cnt  <= '0;
            clk_fall <= 1'b0;
        end else begin
            clk_sr   <= {clk_sr[0], ps2_clk};
            dat_sr   <= {dat_sr[0], ps2_dat};
            clk_fall <= 1'b0;
            // Any sample agreeing with the current level restarts the run.
            if (clk_sr[1] == clk_filt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == CNT_LAST) begin
                clk_filt <= clk_sr[1];
                flt_cnt  <= '0;
                clk_fall <= clk_filt;
            end else begin
                flt_cnt <= flt_cnt + CW'(1);
            end
        end
    end

    assign dat_sync = dat_sr[1];

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 device-to-host frame receiver with E0/F0 prefix folding into key events.
// Optional macro PS2_PARITY_CHECK_EN: reject bad-parity frames with a parity_error pulse.
module ps2_key_receiver
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_release,
    output logic       key_extended,
    output logic       parity_error,
    output logic       frame_error
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BW = $clog2(PS2_FRAME_BITS + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(PS2_FRAME_BITS - 1);

    logic strobe;
    logic dat_s;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_line (
        .clock    (clock),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_dat  (ps2_dat),
        .dat_sync (dat_s),
        .clk_fall (strobe)
    );

    ps2_state_e    state, state_n;
    logic [BW-1:0] bit_cnt, bit_cnt_n;
    logic [7:0]    shift, shift_n;
    logic [TW-1:0] tmo_cnt;
    logic          ext_flag, ext_flag_n;
    logic          brk_flag, brk_flag_n;
    logic          tmo_hit;
    ps2_key_t      key_q, key_n;
    logic          kv_n;
    logic          ferr_n;

`ifdef PS2_PARITY_CHECK_EN
    logic par_bit;
    logic parity_ok;
    logic perr_n;

    always_ff @(posedge clock) begin
        if (reset)
            par_bit <= 1'b0;
        else if (strobe && state == PARITY)
            par_bit <= dat_s;
    end

    assign parity_ok = ps2_odd_parity_ok(shift, par_bit);
`endif

    // A strobe always takes priority over an expiring timeout.
    assign tmo_hit = (state != IDLE) && (tmo_cnt == TMO_LAST);

    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        shift_n    = shift;
        ext_flag_n = ext_flag;
        brk_flag_n = brk_flag;
        key_n      = key_q;
        kv_n       = 1'b0;
        ferr_n     = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        perr_n     = 1'b0;
`endif
        if (strobe) begin
            unique case (state)
                IDLE: begin
                    if (!dat_s) begin
                        state_n   = DATA;
                        bit_cnt_n = '0;
                    end
                end
                DATA: begin
                    shift_n   = {dat_s, shift[7:1]};
                    bit_cnt_n = bit_cnt + BW'(1);
                    if (bit_cnt == LAST_BIT)
                        state_n = PARITY;
                end
                PARITY: state_n = STOP;
                STOP: begin
                    state_n = IDLE;
                    if (!dat_s) begin
                        ferr_n     = 1'b1;
                        ext_flag_n = 1'b0;
                        brk_flag_n = 1'b0;
                    end
`ifdef PS2_PARITY_CHECK_EN
                    else if (!parity_ok) begin
                        perr_n     = 1'b1;
                        ext_flag_n = 1'b0;
                        brk_flag_n = 1'b0;
                    end
`endif
                    else if (shift == PS2_EXT_PREFIX) begin
                        ext_flag_n = 1'b1;
                    end else if (shift == PS2_BREAK_PREFIX) begin
                        brk_flag_n = 1'b1;
                    end else begin
                        kv_n       = 1'b1;
                        key_n      = '{code: shift, brk: brk_flag, ext: ext_flag};
                        ext_flag_n = 1'b0;
                        brk_flag_n = 1'b0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end else if (tmo_hit) begin
            state_n    = IDLE;
            ferr_n     = 1'b1;
            ext_flag_n = 1'b0;
            brk_flag_n = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shift    <= '0;
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            shift    <= shift_n;
            ext_flag <= ext_flag_n;
            brk_flag <= brk_flag_n;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || state == IDLE || strobe || tmo_hit)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + TW'(1);
    end

    // Outputs are registered, so every event lands one cycle after its deciding strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            key_valid   <= 1'b0;
            key_q       <= '0;
            frame_error <= 1'b0;
        end else begin
            key_valid   <= kv_n;
            key_q       <= key_n;
            frame_error <= ferr_n;
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    always_ff @(posedge clock) begin
        if (reset)
            parity_error <= 1'b0;
        else
            parity_error <= perr_n;
    end
`else
    assign parity_error = 1'b0;
`endif

    assign key_code     = key_q.code;
    assign key_release  = key_q.brk;
    assign key_extended = key_q.ext;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Self-checking bench for ps2_key_receiver: directed frame table, randomized frames
// against a prefix-folding reference model, and latency/timeout/glitch/reset sequences.
module tb_ps2_key_receiver;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 1000;
    localparam int HALF       = 30;

    logic       clock = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_dat;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_release;
    logic       key_extended;
    logic       parity_error;
    logic       frame_error;

    int vectors = 0;
    int errors  = 0;

    ps2_key_receiver #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .ps2_clk      (ps2_clk),
        .ps2_dat      (ps2_dat),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .key_release  (key_release),
        .key_extended (key_extended),
        .parity_error (parity_error),
        .frame_error  (frame_error)
    );

    always #10 clock = ~clock;

    // kind: 0 none, 1 key event, 2 parity error, 3 frame error
    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] code;
        logic       rel;
        logic       ext;
    } evt_t;

    typedef struct {
        logic [7:0] data;
        logic       bad_par;
        logic       stop;
        int         glitch;
        logic [1:0] kind;
        logic [7:0] code;
        logic       rel;
        logic       ext;
    } vec_t;

    evt_t evq[$];

    always @(negedge clock) begin
        if (key_valid || parity_error || frame_error) begin
            vectors++;
            if (int'(key_valid) + int'(parity_error) + int'(frame_error) > 1) begin
                errors++;
                $display("FAIL pulse_exclusive: kv=%b perr=%b ferr=%b, want at most one", key_valid, parity_error, frame_error);
            end
            evq.push_back('{kind: key_valid ? 2'd1 : (parity_error ? 2'd2 : 2'd3),
                            code: key_code, rel: key_release, ext: key_extended});
        end
    end

    initial begin
        repeat (90000) @(posedge clock);
        $display("FAIL watchdog: bench exceeded its cycle budget");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    task automatic expect_evt(input string name, input logic [1:0] kind, input logic [7:0] code,
                              input logic rel, input logic ext);
        vectors++;
        if (kind == 2'd0) begin
            if (evq.size() != 0) begin
                errors++;
                $display("FAIL %s: got %0d events (first kind %0d), want none", name, evq.size(), evq[0].kind);
            end
        end else if (evq.size() != 1) begin
            errors++;
            $display("FAIL %s: got %0d events, want one of kind %0d", name, evq.size(), kind);
        end else if (evq[0].kind != kind ||
                     (kind == 2'd1 && (evq[0].code != code || evq[0].rel != rel || evq[0].ext != ext))) begin
            errors++;
            $display("FAIL %s: got kind %0d code %h rel %b ext %b, want kind %0d code %h rel %b ext %b",
                     name, evq[0].kind, evq[0].code, evq[0].rel, evq[0].ext, kind, code, rel, ext);
        end
        evq.delete();
    endtask

    // One PS/2 bit: data changes while the clock is high, host samples on the fall.
    task automatic ps2_bit(input logic b, input bit glitch);
        ps2_dat = b;
        if (glitch) begin
            repeat (14) @(negedge clock);
            ps2_clk = 1'b0;
            repeat (FILTER_LEN - 1) @(negedge clock);
            ps2_clk = 1'b1;
            repeat (HALF - 14 - (FILTER_LEN - 1)) @(negedge clock);
        end else begin
            repeat (HALF) @(negedge clock);
        end
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clock);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop,
                              input int glitch, input int nbits);
        logic [10:0] f;
        f = {stop, (~^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < nbits; i++)
            ps2_bit(f[i], i == glitch);
    endtask

    vec_t       tbl[14];
    logic       m_ext, m_brk;
    logic [7:0] d;
    logic       bp, st;
    logic [1:0] kind;
    int         r;

    initial begin
        tbl[0]  = '{8'h1C, 1'b0, 1'b1, -1, 2'd1, 8'h1C, 1'b0, 1'b0};
        tbl[1]  = '{8'hF0, 1'b0, 1'b1, -1, 2'd0, 8'h00, 1'b0, 1'b0};
        tbl[2]  = '{8'h1C, 1'b0, 1'b1, -1, 2'd1, 8'h1C, 1'b1, 1'b0};
        tbl[3]  = '{8'h1C, 1'b0, 1'b1, -1, 2'd1, 8'h1C, 1'b0, 1'b0};
        tbl[4]  = '{8'hE0, 1'b0, 1'b1, -1, 2'd0, 8'h00, 1'b0, 1'b0};
        tbl[5]  = '{8'hF0, 1'b0, 1'b1, -1, 2'd0, 8'h00, 1'b0, 1'b0};
        tbl[6]  = '{8'h75, 1'b0, 1'b1, -1, 2'd1, 8'h75, 1'b1, 1'b1};
`ifdef PS2_PARITY_CHECK_EN
        tbl[7]  = '{8'h1C, 1'b1, 1'b1, -1, 2'd2, 8'h00, 1'b0, 1'b0};
`else
        tbl[7]  = '{8'h1C, 1'b1, 1'b1, -1, 2'd1, 8'h1C, 1'b0, 1'b0};
`endif
        tbl[8]  = '{8'h33, 1'b0, 1'b0, -1, 2'd3, 8'h00, 1'b0, 1'b0};
        tbl[9]  = '{8'hE0, 1'b0, 1'b1, -1, 2'd0, 8'h00, 1'b0, 1'b0};
        tbl[10] = '{8'h4B, 1'b0, 1'b0, -1, 2'd3, 8'h00, 1'b0, 1'b0};
        tbl[11] = '{8'h4B, 1'b0, 1'b1, -1, 2'd1, 8'h4B, 1'b0, 1'b0};
        tbl[12] = '{8'h5A, 1'b0, 1'b1,  4, 2'd1, 8'h5A, 1'b0, 1'b0};
        tbl[13] = '{8'h6B, 1'b0, 1'b1, -1, 2'd1, 8'h6B, 1'b0, 1'b0};

        reset = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1;
        repeat (5) @(negedge clock);
        chk("reset_key_valid", key_valid, 0);
        chk("reset_key_code", key_code, 0);
        chk("reset_key_release", key_release, 0);
        chk("reset_key_extended", key_extended, 0);
        chk("reset_parity_error", parity_error, 0);
        chk("reset_frame_error", frame_error, 0);
        reset = 1'b0;
        repeat (HALF) @(negedge clock);
        evq.delete();

        // Idle-level strobe (data 1) must be ignored without error.
        ps2_bit(1'b1, 1'b0);
        repeat (HALF) @(negedge clock);
        expect_evt("idle_strobe", 2'd0, 8'h00, 1'b0, 1'b0);

        for (int i = 0; i < 14; i++) begin
            send_frame(tbl[i].data, tbl[i].bad_par, tbl[i].stop, tbl[i].glitch, 11);
            repeat (HALF) @(negedge clock);
            expect_evt($sformatf("table_%0d", i), tbl[i].kind, tbl[i].code, tbl[i].rel, tbl[i].ext);
        end

        m_ext = 1'b0; m_brk = 1'b0;
        for (int n = 0; n < 30; n++) begin
            r  = int'($urandom_range(0, 9));
            d  = (r < 2) ? 8'hE0 : (r < 4) ? 8'hF0 : 8'($urandom_range(0, 255));
            bp = ($urandom_range(0, 7) == 0);
            st = bp ? 1'b1 : ($urandom_range(0, 7) != 0);
            send_frame(d, bp, st, -1, 11);
            repeat (HALF) @(negedge clock);
`ifdef PS2_PARITY_CHECK_EN
            if (bp) st = 1'b0;
`endif
            if (!st) begin
`ifdef PS2_PARITY_CHECK_EN
                kind = bp ? 2'd2 : 2'd3;
`else
                kind = 2'd3;
`endif
                expect_evt($sformatf("rand_%0d", n), kind, 8'h00, 1'b0, 1'b0);
                m_ext = 1'b0; m_brk = 1'b0;
            end else if (d == 8'hE0) begin
                expect_evt($sformatf("rand_%0d", n), 2'd0, 8'h00, 1'b0, 1'b0);
                m_ext = 1'b1;
            end else if (d == 8'hF0) begin
                expect_evt($sformatf("rand_%0d", n), 2'd0, 8'h00, 1'b0, 1'b0);
                m_brk = 1'b1;
            end else begin
                expect_evt($sformatf("rand_%0d", n), 2'd1, d, m_brk, m_ext);
                m_ext = 1'b0; m_brk = 1'b0;
            end
        end

        // Exact latency: 2 sync flops + FILTER_LEN filter samples + 1 output register.
        send_frame(8'h1C, 1'b0, 1'b1, -1, 10);
        ps2_dat = 1'b1;
        repeat (HALF) @(negedge clock);
        ps2_clk = 1'b0;
        for (int k = 1; k <= FILTER_LEN + 4; k++) begin
            @(negedge clock);
            if (k >= FILTER_LEN + 2)
                chk($sformatf("latency_k%0d", k), key_valid, k == FILTER_LEN + 3);
        end
        repeat (HALF - FILTER_LEN - 4) @(negedge clock);
        ps2_clk = 1'b1;
        repeat (HALF) @(negedge clock);
        expect_evt("latency_evt", 2'd1, 8'h1C, m_brk, m_ext);
        chk("code_holds", key_code, 8'h1C);

        // Stalled frame: no early abort, then one frame_error that also clears the break flag.
        send_frame(8'hF0, 1'b0, 1'b1, -1, 11);
        repeat (HALF) @(negedge clock);
        expect_evt("tmo_prefix", 2'd0, 8'h00, 1'b0, 1'b0);
        send_frame(8'h29, 1'b0, 1'b1, -1, 5);
        repeat (TIMEOUT - 50) @(negedge clock);
        expect_evt("tmo_not_early", 2'd0, 8'h00, 1'b0, 1'b0);
        repeat (100) @(negedge clock);
        expect_evt("tmo_frame_error", 2'd3, 8'h00, 1'b0, 1'b0);
        send_frame(8'h29, 1'b0, 1'b1, -1, 11);
        repeat (HALF) @(negedge clock);
        expect_evt("tmo_recover", 2'd1, 8'h29, 1'b0, 1'b0);

        // Reset mid-frame: partial frame and pending break flag are dropped silently.
        send_frame(8'hF0, 1'b0, 1'b1, -1, 11);
        send_frame(8'h12, 1'b0, 1'b1, -1, 4);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("midreset_key_code", key_code, 0);
        reset = 1'b0;
        repeat (HALF) @(negedge clock);
        expect_evt("midreset_quiet", 2'd0, 8'h00, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b1, -1, 11);
        repeat (HALF) @(negedge clock);
        expect_evt("midreset_5A", 2'd1, 8'h5A, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
